// File: rtl/apb3_master_if.sv
// apb3_master_if: APB3 requester for the control-path register bus.
// It takes one read or write command at a time on a valid/ready port, runs the
// APB3 SETUP and ACCESS phases, waits for PREADY, and returns the read data and
// error status on a valid/ready response port. Every output is a register.
//
// Build option: define APB3_MASTER_TIMEOUT_EN to abort an ACCESS phase that
// has waited TIMEOUT_CYCLES cycles without PREADY. The abort returns
// rsp_slverr = 1 and rsp_timeout = 1. When the macro is undefined, ACCESS
// waits indefinitely and rsp_timeout stays 0.
module apb3_master_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    // APB3 bus
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;

`ifdef APB3_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    // The abort is taken on the wait cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] to_cnt;
`else
    // Without the timeout option the depth parameter has no effect.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // Transfer sequencer. A single register block drives every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
`ifdef APB3_MASTER_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR     <= cmd_addr;
                        PWRITE    <= cmd_write;
                        // A read leaves the last write data on the bus.
                        if (cmd_write) PWDATA <= cmd_wdata;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
`ifdef APB3_MASTER_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        // Normal completion has priority over a timeout in the same cycle.
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_slverr  <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end
`ifdef APB3_MASTER_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        to_cnt      <= to_cnt + 1'b1;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_master_if.sv
// Directed bench for apb3_master_if. Inputs are driven 1 time unit after a
// rising edge, and outputs are sampled at the same point.
module tb_apb3_master_if;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [DW-1:0] PWDATA, PRDATA;

    int errors = 0;
    int checks = 0;

    apb3_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for one edge. The command is accepted when the FSM is idle.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Consumes a pending response.
    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if ({rsp_valid, PSEL, PENABLE, PWRITE} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {rsp_valid, PSEL, PENABLE, PWRITE}); end
        checks++; if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {PADDR, PWDATA, rsp_rdata}); end
        checks++; if ({rsp_slverr, rsp_timeout} !== 2'b00) begin errors++; $display("FAIL reset_status got=%b exp=00", {rsp_slverr, rsp_timeout}); end
        rst = 1'b0;
        tick();
        checks++; if ({cmd_ready, PSEL} !== 2'b10) begin errors++; $display("FAIL post_reset_idle got=%b exp=10", {cmd_ready, PSEL}); end
    endtask

    task automatic test_write_zero_wait();
        PREADY = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        checks++; if ({PSEL, PENABLE, cmd_ready} !== 3'b100) begin errors++; $display("FAIL wr_setup got=%b exp=100", {PSEL, PENABLE, cmd_ready}); end
        tick();
        checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b111) begin errors++; $display("FAIL wr_access_ctrl got=%b exp=111", {PSEL, PENABLE, PWRITE}); end
        checks++; if ({PADDR, PWDATA} !== {32'h10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_access_bus got=%h exp=%h", {PADDR, PWDATA}, {32'h10, 32'hDEAD_BEEF}); end
        tick();
        checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b001) begin errors++; $display("FAIL wr_resp_ctrl got=%b exp=001", {PSEL, PENABLE, rsp_valid}); end
        checks++; if ({rsp_rdata, rsp_slverr} !== 33'h0) begin errors++; $display("FAIL wr_resp_fields got=%h exp=0", {rsp_rdata, rsp_slverr}); end
        drain();
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL wr_done got=%b exp=10", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_read_wait();
        int en_cycles = 0;
        PREADY = 1'b0; PRDATA = 32'hFFFF_0000;
        issue(1'b0, 32'h0000_0004, 32'h5555_5555);
        tick();
        // Three wait states, then PREADY in the fourth ACCESS cycle.
        for (int i = 0; i < 4; i++) begin
            if (PENABLE === 1'b1 && PADDR === 32'h4) en_cycles++;
            if (i == 3) begin PREADY = 1'b1; PRDATA = 32'h1234_5678; end
            tick();
        end
        PREADY = 1'b0;
        checks++; if (en_cycles !== 4) begin errors++; $display("FAIL rd_enable_cycles got=%0d exp=4", en_cycles); end
        checks++; if (PWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_pwdata_kept got=%h exp=deadbeef", PWDATA); end
        checks++; if ({rsp_valid, PENABLE} !== 2'b10) begin errors++; $display("FAIL rd_resp_ctrl got=%b exp=10", {rsp_valid, PENABLE}); end
        checks++; if (rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata got=%h exp=12345678", rsp_rdata); end
        drain();
    endtask

    task automatic test_slverr();
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0000_00AA;
        issue(1'b0, 32'h0000_0008, 32'h0);
        tick(); tick();
        checks++; if ({rsp_valid, rsp_slverr, rsp_timeout} !== 3'b110) begin errors++; $display("FAIL err_status got=%b exp=110", {rsp_valid, rsp_slverr, rsp_timeout}); end
        PSLVERR = 1'b0;
        drain();
        checks++; if ({cmd_ready, rsp_slverr} !== 2'b11) begin errors++; $display("FAIL err_fields_after got=%b exp=11", {cmd_ready, rsp_slverr}); end
    endtask

    task automatic test_back_to_back();
        int unstable = 0;
        PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_0020, 32'h0);
        tick(); tick();
        // The second command is offered during backpressure and must be held off.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h0BAD_CAFE;
        PRDATA = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || cmd_ready !== 1'b0 || PADDR !== 32'h20) unstable++;
            tick();
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) begin errors++; $display("FAIL bp_release got=%b exp=100", {cmd_ready, rsp_valid, PSEL}); end
        tick();
        cmd_valid = 1'b0;
        checks++; if ({PSEL, PADDR} !== {1'b1, 32'h24}) begin errors++; $display("FAIL b2b_setup got=%h exp=%h", {PSEL, PADDR}, {1'b1, 32'h24}); end
        tick(); tick();
        checks++; if ({rsp_valid, rsp_slverr, PWDATA, rsp_rdata} !== {2'b10, 32'h0BAD_CAFE, 32'h0}) begin errors++; $display("FAIL b2b_resp got=%h exp=%h", {rsp_valid, rsp_slverr, PWDATA, rsp_rdata}, {2'b10, 32'h0BAD_CAFE, 32'h0}); end
        drain();
    endtask

    task automatic test_reset_mid();
        PREADY = 1'b0;
        issue(1'b0, 32'h0000_0030, 32'h0);
        tick();
        checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL rm_in_access got=%b exp=1", PENABLE); end
        rst = 1'b1;
        tick();
        checks++; if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin errors++; $display("FAIL rm_abort got=%b exp=0001", {PSEL, PENABLE, rsp_valid, cmd_ready}); end
        rst = 1'b0; PREADY = 1'b1;
        tick(); tick();
        checks++; if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) begin errors++; $display("FAIL rm_release got=%b exp=100", {cmd_ready, rsp_valid, PSEL}); end
    endtask

    task automatic test_timeout();
        int en_cycles = 0;
        PREADY = 1'b0;
        issue(1'b0, 32'h0000_0040, 32'h0);
        tick();
`ifdef APB3_MASTER_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            if (PENABLE === 1'b1) en_cycles++;
            tick();
        end
        checks++; if (en_cycles !== 8) begin errors++; $display("FAIL to_wait_cycles got=%0d exp=8", en_cycles); end
        checks++; if ({rsp_valid, rsp_slverr, rsp_timeout, PSEL, PENABLE} !== 5'b11100) begin errors++; $display("FAIL to_abort got=%b exp=11100", {rsp_valid, rsp_slverr, rsp_timeout, PSEL, PENABLE}); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got=%h exp=0", rsp_rdata); end
        drain();
        // PREADY in the last allowed cycle completes normally.
        issue(1'b0, 32'h0000_0044, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin PREADY = 1'b1; PRDATA = 32'h7777_0001; end
            tick();
        end
        PREADY = 1'b0;
        checks++; if ({rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata} !== {3'b100, 32'h7777_0001}) begin errors++; $display("FAIL to_edge_win got=%h exp=%h", {rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}, {3'b100, 32'h7777_0001}); end
        drain();
`else
        for (int i = 0; i < 1000; i++) begin
            if (PENABLE === 1'b1) en_cycles++;
            tick();
        end
        checks++; if (en_cycles !== 1000) begin errors++; $display("FAIL no_to_wait got=%0d exp=1000", en_cycles); end
        checks++; if ({PSEL, PENABLE, rsp_valid, rsp_timeout} !== 4'b1100) begin errors++; $display("FAIL no_to_pending got=%b exp=1100", {PSEL, PENABLE, rsp_valid, rsp_timeout}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb3_master_if.md
Name: apb3_master_if

Overview:
APB3 requester that drives the control-path APB3 bus toward the accelerator's APB3 completer register interface.
- Accepts single register read/write commands on a valid/ready command port.
- Sequences the APB3 SETUP and ACCESS phases and waits for PREADY.
- Returns read data and error status on a valid/ready response port.
- Used by the host-side bridge and by the testbench driver.

Parameters:
ADDR_WIDTH, 32, width of PADDR and cmd_addr
DATA_WIDTH, 32, width of PWDATA/PRDATA and command/response data
TIMEOUT_CYCLES, 256, ACCESS-phase cycles without PREADY before abort (only used with the optional feature)

Ports:
clk  input  1  control clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data, ignored for reads
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
rsp_slverr  output  1  PSLVERR captured, or timeout abort
rsp_timeout  output  1  response came from a timeout abort
PADDR  output  ADDR_WIDTH  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PRDATA  input  DATA_WIDTH  APB read data
PREADY  input  1  completer ready
PSLVERR  input  1  completer error

Behaviour:
- Single clock domain is clk. Reset is synchronous, active-high, on rst.
- All outputs are registered.
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, PSEL 0, PENABLE 0, PWRITE 0, and 0 on PADDR, PWDATA, rsp_rdata, rsp_slverr, rsp_timeout.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA and go to SETUP.
  - For a read, PWDATA keeps its previous value.
- SETUP: PSEL = 1, PENABLE = 0, cmd_ready = 0. Always go to ACCESS after one cycle.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR/PWRITE/PWDATA are held stable from SETUP through the end of ACCESS.
  - Stay in ACCESS while PREADY = 0.
  - When PREADY = 1, capture the response and go to RESP:
    - rsp_rdata = PWRITE ? 0 : PRDATA;
    - rsp_slverr = PSLVERR;
    - rsp_timeout = 0.
  - PSEL and PENABLE drop to 0 on the same edge.
- RESP:
  - rsp_valid = 1. Response fields are held stable until rsp_ready = 1, then go to IDLE.
  - rsp_ready is ignored when rsp_valid = 0.
- Latency, with the command accepted at edge T:
  - PSEL = 1 after T;
  - PENABLE = 1 after T+1;
  - with zero-wait PREADY, rsp_valid = 1 after T+2;
  - cmd_ready = 1 again after rsp_ready is sampled.
  - Each wait state adds 1 cycle.
- Outside a transfer, PADDR/PWRITE/PWDATA hold the last transfer's values.
- Only one transfer is in flight. No command is accepted in SETUP, ACCESS or RESP.
- PREADY and PSLVERR are ignored outside ACCESS.
- Reset mid-transfer: PSEL and PENABLE go to 0 at the next edge and any pending response is discarded.

Optional Feature:
Macro APB3_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES)+1 clears on entering ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, drop PSEL/PENABLE and go to RESP with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If PREADY = 1 in the same cycle the count reaches TIMEOUT_CYCLES, the normal completion wins.
- Not defined: no counter, ACCESS waits indefinitely, and rsp_timeout is tied to 0.

Test Plan:
1. Write, zero wait. cmd write addr 0x0000_0010, data 0xDEAD_BEEF, PREADY tied 1.
   -> PSEL 1 / PENABLE 0 for 1 cycle, then PENABLE 1 for 1 cycle with PADDR = 0x10, PWRITE = 1, PWDATA = 0xDEADBEEF.
   -> rsp_valid with rsp_rdata = 0, rsp_slverr = 0.
2. Read, wait states. Read addr 0x0000_0004; PREADY low for 3 ACCESS cycles, then high with PRDATA = 0x1234_5678.
   -> PENABLE high for 4 cycles with address stable; rsp_rdata = 0x12345678.
3. Error response. Read with PSLVERR = 1 at PREADY.
   -> rsp_slverr = 1, rsp_timeout = 0.
4. Response backpressure. rsp_ready held 0 for 5 cycles.
   -> rsp_valid and its fields are stable and cmd_ready stays 0; after rsp_ready = 1, cmd_ready = 1 on the next cycle.
   -> A back-to-back second command then completes correctly.
5. Reset mid-transfer. rst = 1 during ACCESS.
   -> PSEL = PENABLE = 0 and rsp_valid = 0 after the next edge; cmd_ready = 1 after release.
6. Timeout (APB3_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8). PREADY held 0.
   -> abort after 8 ACCESS cycles with rsp_slverr = 1, rsp_timeout = 1.
   -> Without the macro, the transfer is still pending after 1000 cycles.
